// File: rtl/fifo32x12_ctrl_if.sv
// Stream and status signals between the sample FIFO controller and its users.
// Write side, registered read side, and occupancy/overflow status.
interface fifo32x12_ctrl_if;
  logic        WR_EN;
  logic [11:0] WR_DATA;
  logic        FULL;
  logic        RD_VALID;
  logic        RD_READY;
  logic [11:0] RD_DATA;
  logic [5:0]  LEVEL;
  logic        AFULL;
  logic        OVF;

  modport master (
    output WR_EN, WR_DATA, RD_READY,
    input  FULL, RD_VALID, RD_DATA,
    input  LEVEL, AFULL, OVF
  );

  modport slave (
    input  WR_EN, WR_DATA, RD_READY,
    output FULL, RD_VALID, RD_DATA,
    output LEVEL, AFULL, OVF
  );
endinterface

// File: rtl/fifo32x12_ctrl.sv
// FWFT sample FIFO controller around an external 32x12 SDP distributed RAM.
// Output register stage gives registered valid/ready to the consumer.
module fifo32x12_ctrl #(
  parameter int AFULL_LVL = 24
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   CLR,
  fifo32x12_ctrl_if.slave        io,
  output logic [4:0]             RAM_WADDR,
  output logic [11:0]            RAM_DI,
  output logic                   RAM_WE,
  output logic [4:0]             RAM_RADDR,
  input  logic [11:0]            RAM_DO
);

  localparam logic [5:0] AFL = 6'(AFULL_LVL);

  logic [4:0]  wptr;
  logic [4:0]  rptr;
  logic [5:0]  ram_cnt;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic        ovf;
  logic        full;
  logic        we;
  logic        load;
  logic [5:0]  level;

  assign full  = (ram_cnt == 6'd32);
  assign we    = io.WR_EN & ~full & ~CLR;
  // A word written this edge is not visible on RAM_DO until next cycle
  assign load  = (ram_cnt != 6'd0)
               & (~rd_valid | io.RD_READY);
  assign level = ram_cnt + {5'd0, rd_valid};

  assign RAM_WADDR = wptr;
  assign RAM_DI    = io.WR_DATA;
  assign RAM_WE    = we;
  assign RAM_RADDR = rptr;

  assign io.FULL     = full;
  assign io.RD_VALID = rd_valid;
  assign io.RD_DATA  = rd_data;
  assign io.LEVEL    = level;
  assign io.AFULL    = (level >= AFL);
  assign io.OVF      = ovf;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr     <= 5'd0;
      rptr     <= 5'd0;
      ram_cnt  <= 6'd0;
      rd_valid <= 1'b0;
      rd_data  <= 12'd0;
      ovf      <= 1'b0;
    end else if (CLR) begin
      wptr     <= 5'd0;
      rptr     <= 5'd0;
      ram_cnt  <= 6'd0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (we)
        wptr <= wptr + 5'd1;
      if (load) begin
        rptr     <= rptr + 5'd1;
        rd_data  <= RAM_DO;
        rd_valid <= 1'b1;
      end else if (rd_valid && io.RD_READY) begin
        rd_valid <= 1'b0;
      end
      case ({we, load})
        2'b10:   ram_cnt <= ram_cnt + 6'd1;
        2'b01:   ram_cnt <= ram_cnt - 6'd1;
        default: ram_cnt <= ram_cnt;
      endcase
      if (io.WR_EN && full)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo32x12_ctrl.sv
// Randomized bench for fifo32x12_ctrl with a queue-based reference model.
// Bench owns the external RAM model that the controller addresses.
module tb_fifo32x12_ctrl;
  localparam int AFULL_LVL = 24;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr;
  logic [4:0]  RAM_WADDR;
  logic [11:0] RAM_DI;
  logic        RAM_WE;
  logic [4:0]  RAM_RADDR;
  logic [11:0] RAM_DO;
  logic [11:0] mem [32];

  fifo32x12_ctrl_if bus ();

  fifo32x12_ctrl #(.AFULL_LVL(AFULL_LVL)) dut (
    .CLK       (clk),
    .RSTN      (rstn),
    .CLR       (clr),
    .io        (bus),
    .RAM_WADDR (RAM_WADDR),
    .RAM_DI    (RAM_DI),
    .RAM_WE    (RAM_WE),
    .RAM_RADDR (RAM_RADDR),
    .RAM_DO    (RAM_DO)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (RAM_WE) mem[RAM_WADDR] <= RAM_DI;
  assign RAM_DO = mem[RAM_RADDR];

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] ramq [$];
  logic        m_v;
  logic [11:0] m_d;
  logic        m_ovf;
  int          m_wcnt;

  logic        o_we, e_we;
  logic [4:0]  o_waddr, e_waddr;
  logic [11:0] o_di, e_di;

  function automatic logic [9:0] obs();
    return {bus.RD_VALID, bus.LEVEL, bus.FULL,
            bus.AFULL, bus.OVF};
  endfunction

  function automatic logic [9:0] expv();
    int lvl;
    lvl = ramq.size() + int'(m_v);
    return {m_v, 6'(lvl), ramq.size() == 32,
            lvl >= AFULL_LVL, m_ovf};
  endfunction

  function automatic void model_reset(input bit hard);
    ramq.delete();
    m_v = 1'b0;
    m_ovf = 1'b0;
    m_wcnt = 0;
    if (hard) m_d = 12'd0;
  endfunction

  task automatic step(input logic wr, input logic [11:0] d,
                      input logic rdy, input logic c);
    bit full, load;
    bus.WR_EN = wr;
    bus.WR_DATA = d;
    bus.RD_READY = rdy;
    clr = c;
    #2;
    o_we = RAM_WE;
    o_waddr = RAM_WADDR;
    o_di = RAM_DI;
    full = (ramq.size() == 32);
    load = (ramq.size() != 0) && (!m_v || rdy);
    e_we = wr && !full && !c;
    e_waddr = 5'(m_wcnt);
    e_di = d;
    @(posedge clk);
    if (c) begin
      model_reset(1'b0);
    end else begin
      if (wr && full) m_ovf = 1'b1;
      if (load) begin
        m_d = ramq.pop_front();
        m_v = 1'b1;
      end else if (m_v && rdy) begin
        m_v = 1'b0;
      end
      if (e_we) begin
        ramq.push_back(d);
        m_wcnt = (m_wcnt + 1) % 32;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if (obs() !== expv() || bus.RD_DATA !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%h/%h want=%h/000",
               obs(), bus.RD_DATA, expv());
    end
    for (int i = 0; i < 5; i++)
      step(1'b1, 12'($urandom), 1'b0, 1'b0);
    vectors++;
    if (bus.LEVEL !== 6'd5) begin
      miscompares++;
      $display("FAIL pre_reset_level got=%0d want=5", bus.LEVEL);
    end
    bus.WR_EN = 1'b0;
    rstn = 1'b0;
    model_reset(1'b1);
    #1;
    vectors++;
    if (obs() !== 10'd0 || RAM_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got=%h we=%b want=000 we=0",
               obs(), RAM_WE);
    end
    #2 rstn = 1'b1;
  endtask

  task automatic test_single();
    step(1'b0, 12'd0, 1'b0, 1'b1);
    step(1'b1, 12'hA5C, 1'b0, 1'b0);
    vectors++;
    if (o_we !== 1'b1 || o_waddr !== 5'd0 || o_di !== 12'hA5C) begin
      miscompares++;
      $display("FAIL single_wr got we=%b a=%0d d=%h want 1/0/a5c",
               o_we, o_waddr, o_di);
    end
    vectors++;
    if (bus.LEVEL !== 6'd1 || bus.RD_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL single_lat1 got lvl=%0d v=%b want 1/0",
               bus.LEVEL, bus.RD_VALID);
    end
    step(1'b0, 12'd0, 1'b0, 1'b0);
    vectors++;
    if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 12'hA5C ||
        bus.LEVEL !== 6'd1) begin
      miscompares++;
      $display("FAIL single_out got v=%b d=%h l=%0d want 1/a5c/1",
               bus.RD_VALID, bus.RD_DATA, bus.LEVEL);
    end
    step(1'b0, 12'd0, 1'b1, 1'b0);
  endtask

  task automatic test_fill_overflow();
    logic [11:0] got [$];
    step(1'b0, 12'd0, 1'b0, 1'b1);
    for (int i = 0; i < 34; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b0);
      vectors++;
      if (o_we !== e_we || (e_we && o_waddr !== e_waddr)) begin
        miscompares++;
        $display("FAIL fill_wr[%0d] got we=%b a=%0d want %b/%0d",
                 i, o_we, o_waddr, e_we, e_waddr);
      end
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL fill_st[%0d] got=%h want=%h",
                 i, obs(), expv());
      end
    end
    for (int i = 0; i < 40 && bus.LEVEL != 6'd0; i++) begin
      if (bus.RD_VALID) got.push_back(bus.RD_DATA);
      step(1'b0, 12'd0, 1'b1, 1'b0);
      vectors++;
      if (obs() !== expv() || bus.RD_DATA !== m_d) begin
        miscompares++;
        $display("FAIL drain_st[%0d] got=%h/%h want=%h/%h",
                 i, obs(), bus.RD_DATA, expv(), m_d);
      end
    end
    vectors++;
    if (got.size() != 33) begin
      miscompares++;
      $display("FAIL drain_count got=%0d want=33", got.size());
    end
    foreach (got[i]) begin
      vectors++;
      if (got[i] !== 12'(i)) begin
        miscompares++;
        $display("FAIL drain_ord[%0d] got=%h want=%h",
                 i, got[i], 12'(i));
      end
    end
  endtask

  task automatic test_stream();
    logic [11:0] base;
    base = 12'($urandom);
    step(1'b0, 12'd0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, base + 12'(i), 1'b1, 1'b0);
      vectors++;
      if (obs() !== expv() || bus.RD_DATA !== m_d) begin
        miscompares++;
        $display("FAIL stream[%0d] got=%h/%h want=%h/%h",
                 i, obs(), bus.RD_DATA, expv(), m_d);
      end
      vectors++;
      if (i >= 1 && (bus.LEVEL !== 6'd2 || bus.RD_DATA !==
                     base + 12'(i - 1))) begin
        miscompares++;
        $display("FAIL stream_gap[%0d] got l=%0d d=%h want 2/%h",
                 i, bus.LEVEL, bus.RD_DATA, base + 12'(i - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    pat = 4'b1001;
    step(1'b0, 12'd0, 1'b0, 1'b1);
    for (int i = 0; i < 120; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom),
           pat[i % 4], 1'b0);
      vectors++;
      if (o_we !== e_we || (e_we && o_waddr !== e_waddr)) begin
        miscompares++;
        $display("FAIL bp_wr[%0d] got we=%b a=%0d want %b/%0d",
                 i, o_we, o_waddr, e_we, e_waddr);
      end
      vectors++;
      if (obs() !== expv() || bus.RD_DATA !== m_d) begin
        miscompares++;
        $display("FAIL bp_st[%0d] got=%h/%h want=%h/%h",
                 i, obs(), bus.RD_DATA, expv(), m_d);
      end
    end
  endtask

  task automatic test_clr();
    step(1'b0, 12'd0, 1'b0, 1'b1);
    for (int i = 0; i < 34; i++)
      step(1'b1, 12'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 23; i++)
      step(1'b0, 12'd0, 1'b1, 1'b0);
    vectors++;
    if (bus.LEVEL !== 6'd10 || bus.OVF !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_pre got l=%0d ovf=%b want 10/1",
               bus.LEVEL, bus.OVF);
    end
    step(1'b1, 12'($urandom), 1'b0, 1'b1);
    vectors++;
    if (o_we !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_we got=%b want=0", o_we);
    end
    vectors++;
    if (obs() !== expv() || bus.LEVEL !== 6'd0 ||
        bus.OVF !== 1'b0 || bus.RD_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_st got=%h want=%h", obs(), expv());
    end
    step(1'b1, 12'($urandom), 1'b0, 1'b0);
    vectors++;
    if (o_we !== 1'b1 || o_waddr !== 5'd0) begin
      miscompares++;
      $display("FAIL clr_waddr got we=%b a=%0d want 1/0",
               o_we, o_waddr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 12'($urandom),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 63) == 0));
      vectors++;
      if (o_we !== e_we || (e_we && (o_waddr !== e_waddr ||
                                      o_di !== e_di))) begin
        miscompares++;
        $display("FAIL rnd_wr[%0d] got we=%b a=%0d want %b/%0d",
                 i, o_we, o_waddr, e_we, e_waddr);
      end
      vectors++;
      if (obs() !== expv() || bus.RD_DATA !== m_d) begin
        miscompares++;
        $display("FAIL rnd_st[%0d] got=%h/%h want=%h/%h",
                 i, obs(), bus.RD_DATA, expv(), m_d);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    clr = 1'b0;
    bus.WR_EN = 1'b0;
    bus.WR_DATA = 12'd0;
    bus.RD_READY = 1'b0;
    model_reset(1'b1);
    #12 rstn = 1'b1;
    test_reset();
    test_single();
    test_fill_overflow();
    test_stream();
    test_back_to_back();
    test_clr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
